// File: rtl/tm1638_pkg.sv
// tm1638_pkg: shared command constants, sizes and state encoding for the TM1638 responder
package tm1638_pkg;
    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_DISP = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;
    localparam int READ_BIT = 1;
    localparam int FIXED_BIT = 2;
    localparam int KEY_BYTES = 4;
    localparam int RAM_DEPTH = 16;
    localparam int KEY_BITS = KEY_BYTES * 8;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA, S_IGNORE} state_t;

    // State that follows the first byte of a frame
    function automatic state_t cmd_next(input logic [7:0] b);
        return b[7:6] == CMD_ADDR ? S_WDATA
             : (b[7:6] == CMD_DATA && b[READ_BIT]) ? S_RDATA : S_IGNORE;
    endfunction
endpackage

// File: rtl/tm1638_sync_edge.sv
// tm1638_sync_edge: N-stage input synchronizer with registered-level rise/fall pulses
module tm1638_sync_edge
    import tm1638_pkg::*;
#(
    parameter int   N    = 2,
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [N-1:0] sync_q;
    logic         prev;

    // Synchronizer chain plus one delayed copy for edge detection; resets to the pin's idle level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {N{INIT}};
            prev   <= INIT;
        end else begin
            sync_q <= {sync_q[N-2:0], din};
            prev   <= sync_q[N-1];
        end
    end

    assign level = sync_q[N-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;
endmodule

// File: rtl/tm1638_responder.sv
// tm1638_responder: TM1638 device-side decoder for display writes, display control and key reads
module tm1638_responder
    import tm1638_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        sclk,
    input  logic        dio_in,
    output logic        dio_out,
    output logic        dio_oe,
    input  logic [31:0] key_data,
    output logic        ram_we,
    output logic [3:0]  ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        disp_on,
    output logic [2:0]  brightness,
    output logic        keys_read,
    output logic        frame_err
);
    state_t                        state, state_n;
    logic                          stb_lvl, stb_rise, stb_fall;
    logic                          sclk_lvl, sclk_rise, sclk_fall;
    logic                          dio_s, dio_rise, dio_fall;
    logic                          unused_sync;
    logic [2:0]                    bit_cnt;
    logic [7:0]                    shreg, byte_v;
    logic                          fixed;
    logic [KEY_BITS-1:0]           key_sh;
    logic [$clog2(KEY_BITS)-1:0]   key_cnt;
    logic                          rise_seen, active, done, last_key;

    tm1638_sync_edge #(.N(SYNC_STAGES), .INIT(1'b1)) u_stb (
        .clk(clk), .rst(rst), .din(stb), .level(stb_lvl), .rise(stb_rise), .fall(stb_fall));
    tm1638_sync_edge #(.N(SYNC_STAGES), .INIT(1'b1)) u_sclk (
        .clk(clk), .rst(rst), .din(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    tm1638_sync_edge #(.N(SYNC_STAGES), .INIT(1'b0)) u_dio (
        .clk(clk), .rst(rst), .din(dio_in), .level(dio_s), .rise(dio_rise), .fall(dio_fall));

    assign unused_sync = ^{stb_lvl, sclk_lvl, dio_rise, dio_fall};
    assign byte_v   = {dio_s, shreg[7:1]};
    assign active   = state != S_IDLE && sclk_rise && !stb_rise && !stb_fall;
    assign done     = active && bit_cnt == 3'd7;
    assign last_key = active && state == S_RDATA && key_cnt == ($clog2(KEY_BITS))'(KEY_BITS - 1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next state: STB edges dominate, then the command byte, then the end of a key read
    always_comb begin
        state_n = state;
        if (stb_rise)                   state_n = S_IDLE;
        else if (stb_fall)              state_n = S_CMD;
        else if (done && state == S_CMD) state_n = cmd_next(byte_v);
        else if (last_key)              state_n = S_IGNORE;
    end

    // Datapath: bit assembly, command side effects, RAM writes and key shift-out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            fixed      <= 1'b0;
            key_sh     <= '0;
            key_cnt    <= '0;
            rise_seen  <= 1'b0;
            dio_out    <= 1'b0;
            dio_oe     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            disp_on    <= 1'b0;
            brightness <= '0;
            keys_read  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            ram_we    <= 1'b0;
            keys_read <= 1'b0;
            frame_err <= 1'b0;
            if (ram_we && !fixed) ram_addr <= ram_addr + 4'd1;
            if (stb_rise) begin
                frame_err <= bit_cnt != 3'd0;
                bit_cnt   <= '0;
                shreg     <= '0;
                dio_oe    <= 1'b0;
                dio_out   <= 1'b0;
            end else if (stb_fall) begin
                bit_cnt <= '0;
            end else if (active) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= byte_v;
                if (state == S_RDATA) begin
                    key_cnt   <= key_cnt + 1'b1;
                    rise_seen <= 1'b1;
                end
                if (last_key) begin
                    dio_oe    <= 1'b0;
                    dio_out   <= 1'b0;
                    keys_read <= 1'b1;
                end
                if (done && state == S_WDATA) begin
                    ram_we    <= 1'b1;
                    ram_wdata <= byte_v;
                end
                if (done && state == S_CMD) begin
                    if (byte_v[7:6] == CMD_DATA) begin
                        fixed <= byte_v[FIXED_BIT];
                        if (byte_v[READ_BIT]) begin
                            key_sh    <= key_data;
                            key_cnt   <= '0;
                            rise_seen <= 1'b0;
                            dio_oe    <= 1'b1;
                            dio_out   <= key_data[0];
                        end
                    end
                    if (byte_v[7:6] == CMD_ADDR) ram_addr <= byte_v[3:0];
                    if (byte_v[7:6] == CMD_DISP) begin
                        disp_on    <= byte_v[3];
                        brightness <= byte_v[2:0];
                    end
                end
            end else if (sclk_fall && state == S_RDATA && rise_seen) begin
                key_sh    <= key_sh >> 1;
                dio_out   <= key_sh[1];
                rise_seen <= 1'b0;
            end
        end
    end
endmodule

// File: doc/tm1638_responder.md
Name: tm1638_responder

Overview:
- Device-side (responder) model of the TM1638 three-wire serial link: STB, SCLK, DIO.
- Samples the host's STB/SCLK/DIO with the system clock and decodes the command bytes.
- Writes display bytes into an external 16x8 display RAM and serves the 32-bit key-scan word back on DIO.
- Used to emulate a TM1638 board in FPGA-to-FPGA links and as the bus-functional target in host-controller benches.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers on stb, sclk and dio_in (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the SCLK rate.
- rst  input  1  reset; asynchronous assert, active-high.
- stb  input  1  host strobe, active low; frames each transaction.
- sclk  input  1  host serial clock, idles high.
- dio_in  input  1  host data, LSB first, sampled on SCLK rising edge.
- dio_out  output  1  responder data during key read.
- dio_oe  output  1  responder drives DIO when 1; pad is open-drain or tristate outside this block.
- key_data  input  32  key-scan bytes; byte0 = [7:0], sent first.
- ram_we  output  1  one-cycle display RAM write strobe.
- ram_addr  output  4  display RAM address.
- ram_wdata  output  8  display RAM write data.
- disp_on  output  1  display enable from the display-control command.
- brightness  output  3  pulse-width setting from the display-control command.
- keys_read  output  1  one-cycle pulse when the 32nd key bit has been shifted out.
- frame_err  output  1  one-cycle pulse when STB rises with a partial byte (bit count not 0).

Behaviour:
- Reset values: dio_out=0, dio_oe=0, ram_we=0, ram_addr=0, ram_wdata=0, disp_on=0, brightness=0, keys_read=0, frame_err=0. Mode register: write, auto-increment. State S_IDLE.
- Reset mid-transaction aborts immediately. DIO is released in the same clk period as reset assertion.
- Each input passes through a SYNC_STAGES synchronizer and then an edge detector.
- Every event (STB fall/rise, SCLK rise/fall) acts SYNC_STAGES+1 clk cycles after the pin transition.
- Byte assembly: shift register right-shifts the synced dio_in on each SCLK rise, LSB first. A 3-bit counter marks the byte complete on its 8th rise; the counter wraps 7->0.
- A synced STB fall enters S_CMD and clears the bit counter.
- A synced STB rise from any state returns to S_IDLE, sets dio_oe=0 and discards any partial byte. It pulses frame_err if the bit count is not 0.
- S_CMD: the first complete byte is decoded on bits [7:6].
  - 01 (data command): bit1=1 means read keys, bit0 is ignored; bit2=1 means fixed address. Bit2 is stored in the persistent mode register.
    - Read: latch key_data into a 32-bit shifter, set dio_oe=1 and dio_out=bit0 in the cycle after byte completion, then go to S_RDATA.
    - Write: go to S_IGNORE.
  - 11 (address command): ram_addr<=byte[3:0], go to S_WDATA.
  - 10 (display control): disp_on<=byte[3], brightness<=byte[2:0], go to S_IGNORE.
  - 00: ignored, go to S_IGNORE.
- S_WDATA: each complete byte sets ram_wdata=byte and pulses ram_we for 1 cycle at the current ram_addr.
  - The address advances the cycle after the write in auto mode and wraps 15->0. In fixed mode it holds.
  - Unlimited bytes per frame.
- S_RDATA:
  - On each synced SCLK fall after a rise, shift right and present the next bit on dio_out.
  - After the 32nd rise, dio_out=0 and dio_oe=0, keys_read pulses, go to S_IGNORE.
  - Rises beyond 32 are ignored.
- S_IGNORE: consumes clocks until STB rises.
- Simultaneous STB rise and SCLK rise in the same clk cycle: the STB rise wins and the bit is discarded.
- SCLK edges while in S_IDLE are ignored.

Decomposition:
- Shared package tm1638_pkg:
  - command-class constants CMD_DATA=2'b01, CMD_DISP=2'b10, CMD_ADDR=2'b11;
  - data-command bit indices READ_BIT=1, FIXED_BIT=2;
  - state encoding S_IDLE, S_CMD, S_WDATA, S_RDATA, S_IGNORE;
  - KEY_BYTES=4, RAM_DEPTH=16.
- Sub-module tm1638_sync_edge: an N-stage synchronizer plus rise/fall pulse outputs, instantiated for stb, sclk and dio_in. For dio_in only the level output is used.

Test Plan:
- Write 0x40, then address 0xC0 plus 16 bytes 0x00..0x0F in one frame -> 16 ram_we pulses at addr 0..15 with wdata = addr; no frame_err.
- Fixed mode: 0x44, then 0xC5 plus 3 bytes 0xAA, 0xBB, 0xCC -> three writes, all to addr 5.
- Auto-increment wrap: 0x40, then 0xCE plus 4 bytes -> writes at addresses 14, 15, 0, 1.
- Display control 0x8B -> disp_on=1, brightness=3; 0x80 -> disp_on=0, brightness=0.
- Key read:
  - Stimulus: key_data=0x12345678, then command 0x42 and 32 SCLK pulses.
  - Response: the host samples 0x78, 0x56, 0x34, 0x12, LSB first; keys_read pulses once; dio_oe=0 afterwards.
- Abort cases:
  - STB raised after 3 bits of an address byte -> frame_err pulse, no ram_we, state S_IDLE.
  - rst asserted mid-read -> dio_oe=0 immediately; all outputs at reset values.
